// File: rtl/vga_sync_receiver.sv
// VGA receive side: recovers pixel coordinates, measures line/frame totals, locks, and captures active pixels.
// Optional per-frame colour sum is built when VSR_FRAME_SUM_EN is defined.
module vga_sync_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_LEN   = 640,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_LEN   = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [7:0]  VGA_R,
  input  logic [7:0]  VGA_G,
  input  logic [7:0]  VGA_B,
  output logic        cap_valid,
  output logic [9:0]  cap_x,
  output logic [9:0]  cap_y,
  output logic [7:0]  cap_r,
  output logic [7:0]  cap_g,
  output logic [7:0]  cap_b,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  h_meas,
  output logic [9:0]  v_meas,
  output logic [7:0]  err_count,
  output logic [23:0] frame_sum,
  output logic        frame_sum_valid
);

  localparam int unsigned CW = 10;
  localparam logic [1:0] ST_UNLOCK = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW:0]   H_TOT_W   = 11'(H_TOTAL);
  localparam logic [CW:0]   V_TOT_W   = 11'(V_TOTAL);
  localparam logic [CW-1:0] H_BEG     = 10'(H_ACT_START);
  localparam logic [CW-1:0] V_BEG     = 10'(V_ACT_START);
  localparam logic [CW:0]   H_END     = 11'(H_ACT_START + H_ACT_LEN);
  localparam logic [CW:0]   V_END     = 11'(V_ACT_START + V_ACT_LEN);
  localparam logic [3:0]    LOCK_N    = 4'(LOCK_FRAMES);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;
  logic [CW-1:0] cap_x_q, cap_x_d, cap_y_q, cap_y_d;
  logic [7:0]    cap_r_q, cap_r_d, cap_g_q, cap_g_d, cap_b_q, cap_b_d;
  logic [7:0]    err_q, err_d;
  logic [3:0]    good_q, good_d;
  logic          prev_hs_q, prev_hs_d, prev_vs_q, prev_vs_d;
  logic          line_bad_q, line_bad_d, locked_q, locked_d;
  logic          cap_valid_q, cap_valid_d, frame_start_q, frame_start_d;

  logic          hs_fall, vs_fall, h_bad, frame_good, timeout, err_inc;
  logic [CW:0]   h_inc, v_inc;

  assign hs_fall = prev_hs_q & ~VGA_HS;
  assign vs_fall = prev_vs_q & ~VGA_VS;
  assign h_inc   = {1'b0, h_cnt_q} + 11'd1;
  assign v_inc   = {1'b0, v_cnt_q} + 11'd1;

  // Next-state: counters, measurement, lock FSM and capture, all gated by the pixel strobe
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_meas_d      = h_meas_q;
    v_meas_d      = v_meas_q;
    cap_x_d       = cap_x_q;
    cap_y_d       = cap_y_q;
    cap_r_d       = cap_r_q;
    cap_g_d       = cap_g_q;
    cap_b_d       = cap_b_q;
    err_d         = err_q;
    good_d        = good_q;
    prev_hs_d     = prev_hs_q;
    prev_vs_d     = prev_vs_q;
    line_bad_d    = line_bad_q;
    locked_d      = locked_q;
    cap_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    h_bad         = 1'b0;
    frame_good    = 1'b0;
    timeout       = 1'b0;
    err_inc       = 1'b0;

    if (pix_en) begin
      prev_hs_d  = VGA_HS;
      prev_vs_d  = VGA_VS;
      h_bad      = hs_fall && (h_inc != H_TOT_W);
      frame_good = vs_fall && (v_inc == V_TOT_W) && !line_bad_q && !h_bad;

      if (hs_fall) begin
        h_meas_d = h_inc[CW-1:0];
        h_cnt_d  = '0;
        if (v_cnt_q != CNT_MAX) v_cnt_d = v_inc[CW-1:0];
      end else if (h_cnt_q != CNT_MAX) begin
        h_cnt_d = h_inc[CW-1:0];
      end

      // VS clears after the line check so the closing line still counts against the frame
      if (vs_fall) begin
        v_meas_d   = v_inc[CW-1:0];
        v_cnt_d    = '0;
        line_bad_d = 1'b0;
      end else begin
        line_bad_d = line_bad_q | h_bad;
      end

      timeout = !hs_fall && (h_cnt_d == CNT_MAX);

      case (state_q)
        ST_UNLOCK: begin
          if (vs_fall) begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_ACQ: begin
          if (vs_fall) begin
            if (frame_good) begin
              good_d = 4'(good_q + 4'd1);
              if (4'(good_q + 4'd1) >= LOCK_N) begin
                state_d  = ST_LOCK;
                locked_d = 1'b1;
              end
            end else begin
              good_d = '0;
            end
          end
        end
        ST_LOCK: begin
          if (h_bad || (vs_fall && !frame_good)) begin
            state_d  = ST_ACQ;
            locked_d = 1'b0;
            good_d   = '0;
            err_inc  = 1'b1;
          end
        end
        default: state_d = ST_UNLOCK;
      endcase

      if (timeout) begin
        state_d  = ST_UNLOCK;
        locked_d = 1'b0;
        good_d   = '0;
        err_inc  = (state_q == ST_LOCK);
      end

      if (err_inc && (err_q != 8'hFF)) err_d = 8'(err_q + 8'd1);

      if ((state_q == ST_LOCK) &&
          (h_cnt_d >= H_BEG) && ({1'b0, h_cnt_d} < H_END) &&
          (v_cnt_d >= V_BEG) && ({1'b0, v_cnt_d} < V_END)) begin
        cap_valid_d   = 1'b1;
        cap_x_d       = h_cnt_d - H_BEG;
        cap_y_d       = v_cnt_d - V_BEG;
        cap_r_d       = VGA_R;
        cap_g_d       = VGA_G;
        cap_b_d       = VGA_B;
        frame_start_d = (h_cnt_d == H_BEG) && (v_cnt_d == V_BEG);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= ST_UNLOCK;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      cap_x_q       <= '0;
      cap_y_q       <= '0;
      cap_r_q       <= '0;
      cap_g_q       <= '0;
      cap_b_q       <= '0;
      err_q         <= '0;
      good_q        <= '0;
      prev_hs_q     <= 1'b1;
      prev_vs_q     <= 1'b1;
      line_bad_q    <= 1'b0;
      locked_q      <= 1'b0;
      cap_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      cap_x_q       <= cap_x_d;
      cap_y_q       <= cap_y_d;
      cap_r_q       <= cap_r_d;
      cap_g_q       <= cap_g_d;
      cap_b_q       <= cap_b_d;
      err_q         <= err_d;
      good_q        <= good_d;
      prev_hs_q     <= prev_hs_d;
      prev_vs_q     <= prev_vs_d;
      line_bad_q    <= line_bad_d;
      locked_q      <= locked_d;
      cap_valid_q   <= cap_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cap_valid   = cap_valid_q;
  assign cap_x       = cap_x_q;
  assign cap_y       = cap_y_q;
  assign cap_r       = cap_r_q;
  assign cap_g       = cap_g_q;
  assign cap_b       = cap_b_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign err_count   = err_q;

`ifdef VSR_FRAME_SUM_EN
  logic [23:0] acc_q, acc_d, fsum_q, fsum_d;
  logic        fsv_q, fsv_d;
  logic [23:0] pix_sum;

  assign pix_sum = 24'(VGA_R) + 24'(VGA_G) + 24'(VGA_B);

  // A pixel captured on the latching strobe belongs to the new frame
  always_comb begin
    acc_d  = acc_q;
    fsum_d = fsum_q;
    fsv_d  = 1'b0;
    if (cap_valid_d) acc_d = acc_q + pix_sum;
    if (pix_en && vs_fall && (state_q == ST_LOCK)) begin
      fsum_d = acc_q;
      fsv_d  = 1'b1;
      acc_d  = cap_valid_d ? pix_sum : 24'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc_q  <= '0;
      fsum_q <= '0;
      fsv_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      fsum_q <= fsum_d;
      fsv_q  <= fsv_d;
    end
  end

  assign frame_sum       = fsum_q;
  assign frame_sum_valid = fsv_q;
`else
  assign frame_sum       = '0;
  assign frame_sum_valid = 1'b0;
`endif

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Recovers pixel coordinates and colour from a VGA-style stream (HS, VS, 8-bit R/G/B) sampled on a pixel-enable strobe.
- Measures line and frame totals and runs a lock state machine.
- Emits one captured active pixel per strobe while locked.
- Sits on the receive side of the VGA interface, as the checker/capture end of the timing generator. Used for on-board loopback and frame capture.

Parameters:
H_TOTAL, 800, expected pixels per line
V_TOTAL, 525, expected lines per frame
H_ACT_START, 144, first active pixel index after HS fall
H_ACT_LEN, 640, active pixels per line
V_ACT_START, 35, first active line index after VS fall
V_ACT_LEN, 480, active lines per frame
LOCK_FRAMES, 2, consecutive good frames needed to lock (1..15)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous reset, active-high
pix_en  in  1  pixel strobe; inputs are sampled only when high
VGA_HS  in  1  horizontal sync, active-low
VGA_VS  in  1  vertical sync, active-low
VGA_R / VGA_G / VGA_B  in  8 each  pixel colour
cap_valid  out  1  captured active pixel this cycle
cap_x  out  10  active x (0..H_ACT_LEN-1)
cap_y  out  10  active y (0..V_ACT_LEN-1)
cap_r / cap_g / cap_b  out  8 each  captured colour
frame_start  out  1  pulse with the cap_valid of pixel (0,0)
locked  out  1  receiver locked
h_meas  out  10  last measured line length
v_meas  out  10  last measured frame length in lines
err_count  out  8  lock-loss events, saturating at 255

Behaviour:
- Reset: all outputs 0; h_cnt=v_cnt=0; good_cnt=0; prev_hs=prev_vs=1; state UNLOCK.
- Sampling:
  - Everything below advances only on cycles with pix_en=1; otherwise all registers hold.
  - Pulse outputs (cap_valid, frame_start) are 0 on cycles without pix_en.
- Edge detect: HS fall = prev_hs=1 and VGA_HS=0; VS fall likewise. prev_* update on every strobe.
- h counter:
  - On HS fall: h_meas<=h_cnt+1, h_cnt<=0, v_cnt<=v_cnt+1 (saturates at 1023).
  - Otherwise: h_cnt+1, saturating at 1023.
  - Sample index n after an HS fall has h_cnt=n; the falling sample itself is 0.
- VS fall:
  - v_meas<=v_cnt+1, v_cnt<=0.
  - When HS and VS fall on the same sample, both counters clear (VS has priority over the v_cnt increment).
- line_bad: sticky flag, set on any HS fall with h_cnt+1 != H_TOTAL; cleared at each VS fall after evaluation.
- Frame good: at VS fall, v_cnt+1==V_TOTAL and line_bad=0 (including the current sample's line check).
- FSM:
  - UNLOCK: on first VS fall -> ACQ, good_cnt=0 (no frame evaluation).
  - ACQ:
    - Each VS fall: good frame -> good_cnt+1; bad -> good_cnt=0.
    - When good_cnt reaches LOCK_FRAMES -> LOCK, locked<=1, effective on the same registered update.
  - LOCK:
    - Any bad HS fall or bad frame -> ACQ, locked<=0, good_cnt=0, err_count+1 (saturating). Takes effect at that strobe.
  - Any state: h_cnt reaching 1023 (no HS) -> UNLOCK, locked<=0. If leaving LOCK this way, err_count+1.
- Capture:
  - Registered, 1 CLOCK_50 latency after the sampled strobe.
  - cap_valid=1 iff state LOCK (before this strobe's update) and H_ACT_START<=h_cnt<H_ACT_START+H_ACT_LEN and V_ACT_START<=v_cnt<V_ACT_START+V_ACT_LEN, using the post-update counter values.
  - cap_x=h_cnt-H_ACT_START; cap_y=v_cnt-V_ACT_START; colours copied.
  - cap_x, cap_y and colours hold their last values when not valid.
- Width rules: all subtractions are 10-bit and are only evaluated inside the window, so no wrap is visible.
- Reset mid-frame: immediate return to reset values; relock needs a fresh VS fall plus LOCK_FRAMES good frames.

Optional Feature:
VSR_FRAME_SUM_EN
- Defined:
  - Adds outputs frame_sum (24 bit) and frame_sum_valid (1 bit).
  - frame_sum accumulates R+G+B of every cap_valid pixel, modulo 2^24.
  - At each VS fall while LOCK, the accumulated value is latched to frame_sum with a 1-cycle frame_sum_valid pulse, and the accumulator clears.
  - Reset clears everything.
- Undefined: no accumulator logic is built; frame_sum=0 and frame_sum_valid=0 constant.

Test Plan:
- Ideal 800x525 timing, HS low 96 px, VS low 2 lines, pix_en every 2nd cycle, LOCK_FRAMES=2 -> locked rises at the 3rd VS fall; h_meas=800, v_meas=525; err_count=0.
- Locked; pixel at h=144, v=35 with R=0x7F, G=0x11, B=0x00 -> next cycle cap_valid=1, cap_x=0, cap_y=0, cap_r=0x7F, cap_g=0x11, frame_start=1. At h=783, v=514: cap_x=639, cap_y=479. h=784 -> cap_valid=0.
- Locked; one line of 799 px -> at that HS fall locked=0, err_count=1, h_meas=799. Relock after 2 subsequent good frames.
- HS held high for 1100 strobes -> state UNLOCK and locked=0 at h_cnt=1023. h_meas is unchanged, then recovers after the next VS fall plus 2 good frames.
- Assert reset for 1 cycle mid-line while locked -> next cycle all outputs 0, no cap_valid until relock.
- VSR_FRAME_SUM_EN defined, constant colour R=1, G=2, B=3 -> frame_sum=307200*6 mod 2^24=1843200 with a 1-cycle frame_sum_valid at the VS fall.
